// File: rtl/seq_hit_window_cnt.sv
// Counts sequence-detector hits over a programmable window and hands the result downstream via valid/ready.
// Optional drop counter for hits outside the window: define HIT_DROP_CNT_EN.
module seq_hit_window_cnt #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             hit_in,
  output logic             busy,
  output logic             cnt_vld,
  input  logic             cnt_rdy,
  output logic [CNT_W-1:0] hit_cnt,
`ifdef HIT_DROP_CNT_EN
  output logic [CNT_W-1:0] drop_cnt,
`endif
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_n;
  logic [WIN_W-1:0] win_cnt, win_cnt_n;
  logic [CNT_W-1:0] hit_cnt_n;
  logic             ovf_n, busy_n, cnt_vld_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      win_cnt <= '0;
      hit_cnt <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      cnt_vld <= 1'b0;
    end else begin
      state   <= state_n;
      win_cnt <= win_cnt_n;
      hit_cnt <= hit_cnt_n;
      ovf     <= ovf_n;
      busy    <= busy_n;
      cnt_vld <= cnt_vld_n;
    end
  end

  always_comb begin
    state_n   = state;
    win_cnt_n = win_cnt;
    hit_cnt_n = hit_cnt;
    ovf_n     = ovf;
    busy_n    = busy;
    cnt_vld_n = cnt_vld;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = COUNT;
          win_cnt_n = (win_len == '0) ? WIN_ONE : win_len;
          hit_cnt_n = '0;
          ovf_n     = 1'b0;
          busy_n    = 1'b1;
        end
      end
      COUNT: begin
        win_cnt_n = win_cnt - WIN_ONE;
        if (hit_in) begin
          if (hit_cnt == CNT_MAX) ovf_n = 1'b1;
          else                    hit_cnt_n = hit_cnt + CNT_ONE;
        end
        // The last counted cycle still takes its hit; result is valid on the same edge.
        if (win_cnt <= WIN_ONE) begin
          state_n   = REPORT;
          cnt_vld_n = 1'b1;
        end
      end
      REPORT: begin
        if (cnt_rdy) begin
          state_n   = IDLE;
          cnt_vld_n = 1'b0;
          busy_n    = 1'b0;
        end
      end
      default: begin
        state_n   = IDLE;
        cnt_vld_n = 1'b0;
        busy_n    = 1'b0;
      end
    endcase
  end

`ifdef HIT_DROP_CNT_EN
  // Hits arriving outside COUNT are lost to the window; tally them, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (hit_in && state != COUNT && drop_cnt != CNT_MAX)
      drop_cnt <= drop_cnt + CNT_ONE;
  end
`endif

endmodule

// File: tb/tb_seq_hit_window_cnt.sv
// Directed self-checking bench for seq_hit_window_cnt; expected values are hand-computed.
module tb_seq_hit_window_cnt;

  localparam int CNT_W = 8;
  localparam int WIN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, start, hit_in, cnt_rdy;
  logic [WIN_W-1:0] win_len;
  logic             busy, cnt_vld, ovf;
  logic [CNT_W-1:0] hit_cnt;
`ifdef HIT_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int bcnt;

  seq_hit_window_cnt #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .win_len (win_len),
    .hit_in  (hit_in),
    .busy    (busy),
    .cnt_vld (cnt_vld),
    .cnt_rdy (cnt_rdy),
    .hit_cnt (hit_cnt),
`ifdef HIT_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic b, input logic v,
                         input logic [CNT_W-1:0] h, input logic o);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".vld"},  32'(cnt_vld), 32'(v));
    chk({tag, ".hit"},  32'(hit_cnt), 32'(h));
    chk({tag, ".ovf"},  32'(ovf), 32'(o));
  endtask

  task automatic do_start(input int len);
    win_len = WIN_W'(len);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hit_in = 1'b0; cnt_rdy = 1'b0; win_len = '0;
    tick(); tick();
    chk_out("reset", 1'b0, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;

    // 1: 10-cycle window, hits on cycles 2, 5, 10
    cnt_rdy = 1'b1;
    hit_in  = 1'b1;              // ignored in IDLE
    do_start(10);
    hit_in  = 1'b0;
    chk_out("t1.start", 1'b1, 1'b0, 8'd0, 1'b0);
    bcnt = 0;
    for (int k = 1; k <= 10; k++) begin
      if (busy) bcnt++;
      hit_in = (k == 2 || k == 5 || k == 10);
      tick();
    end
    hit_in = 1'b0;
    chk_out("t1.report", 1'b1, 1'b1, 8'd3, 1'b0);
    if (busy) bcnt++;
    tick();
    chk_out("t1.done", 1'b0, 1'b0, 8'd3, 1'b0);
    chk("t1.busy_cycles", 32'(bcnt), 32'd11);

    // 2: win_len=0 -> one-cycle window
    do_start(0);
    hit_in = 1'b1;
    tick();
    hit_in = 1'b0;
    chk_out("t2.report", 1'b1, 1'b1, 8'd1, 1'b0);
    tick();
    chk_out("t2.done", 1'b0, 1'b0, 8'd1, 1'b0);

    // 3a: exactly 255 hits fill the counter without overflow
    do_start(255);
    hit_in = 1'b1;
    repeat (255) tick();
    hit_in = 1'b0;
    chk_out("t3.full", 1'b1, 1'b1, 8'd255, 1'b0);
    tick();

    // 3b: 300 hits saturate and flag overflow
    do_start(300);
    hit_in = 1'b1;
    repeat (300) tick();
    hit_in = 1'b0;
    chk_out("t3.sat", 1'b1, 1'b1, 8'd255, 1'b1);
    tick();
    chk_out("t3.sat_hold", 1'b0, 1'b0, 8'd255, 1'b1);

    // 3c: next window clears count and ovf at start
    do_start(6);
    chk_out("t3.clear", 1'b1, 1'b0, 8'd0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      hit_in = (k != 3 && k != 5);
      tick();
    end
    hit_in = 1'b0;
    chk_out("t3.four", 1'b1, 1'b1, 8'd4, 1'b0);
    tick();

    // 4: backpressure with hit_in/start toggling during REPORT
    cnt_rdy = 1'b0;
    do_start(3);
    hit_in = 1'b1; tick();
    hit_in = 1'b0; tick(); tick();
    chk_out("t4.report", 1'b1, 1'b1, 8'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      hit_in = k[0];
      start  = ~k[0];
      tick();
      chk_out("t4.hold", 1'b1, 1'b1, 8'd1, 1'b0);
    end
    hit_in  = 1'b0;
    start   = 1'b1;              // coincides with transfer: dropped
    cnt_rdy = 1'b1;
    tick();
    start   = 1'b0;
    chk_out("t4.xfer", 1'b0, 1'b0, 8'd1, 1'b0);
    tick();
    chk_out("t4.no_restart", 1'b0, 1'b0, 8'd1, 1'b0);

    // 5a: reset mid-COUNT
    do_start(10);
    hit_in = 1'b1;
    repeat (3) tick();
    chk("t5.partial", 32'(hit_cnt), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; hit_in = 1'b0;
    chk_out("t5.rst_count", 1'b0, 1'b0, 8'd0, 1'b0);
    tick();
    chk_out("t5.idle_after", 1'b0, 1'b0, 8'd0, 1'b0);

    // 5b: reset while result pending in REPORT
    cnt_rdy = 1'b0;
    do_start(2);
    hit_in = 1'b1;
    repeat (2) tick();
    hit_in = 1'b0;
    chk_out("t5.pend", 1'b1, 1'b1, 8'd2, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_out("t5.rst_report", 1'b0, 1'b0, 8'd0, 1'b0);

    // 5c: normal operation after reset
    cnt_rdy = 1'b1;
    do_start(2);
    hit_in = 1'b1; tick();
    hit_in = 1'b0; tick();
    chk_out("t5.restart", 1'b1, 1'b1, 8'd1, 1'b0);
    tick();
    chk_out("t5.restart_done", 1'b0, 1'b0, 8'd1, 1'b0);

`ifdef HIT_DROP_CNT_EN
    // 6: hits outside the window are tallied in drop_cnt
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t6.rst", 32'(drop_cnt), 32'd0);
    hit_in = 1'b1;
    repeat (3) tick();
    hit_in = 1'b0;
    chk("t6.idle", 32'(drop_cnt), 32'd3);
    cnt_rdy = 1'b0;
    do_start(2);
    hit_in = 1'b1;
    repeat (2) tick();
    chk("t6.win", 32'(drop_cnt), 32'd3);
    repeat (2) tick();           // two hits while in REPORT
    hit_in = 1'b0;
    chk("t6.report", 32'(drop_cnt), 32'd5);
    chk_out("t6.out", 1'b1, 1'b1, 8'd2, 1'b0);
    cnt_rdy = 1'b1;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
